hls_alu_chain: RTL and testbench

Parametrised HLS RTL black-box arithmetic unit with a full `ap_ctrl_chain` handshake. It supports add, subtract and accumulate modes on `WIDTH`-bit operands, with a configurable pipeline latency. It honours `ap_ce` and `ap_continue`, and it sits behind the HLS-generated caller as a drop-in replacement for the single-cycle `ap_ctrl_hs` add black-box.

---
 rtl/hls_alu_chain.sv | 132 +++++++++++++
 tb/tb_hls_alu_chain.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hls_alu_chain.sv
// Add/subtract/accumulate black-box with an ap_ctrl_chain handshake and
// configurable latency. Operands are captured at start; results load at E(LATENCY-1).
module hls_alu_chain #(
    parameter int WIDTH   = 5,
    parameter int LATENCY = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_ce,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             ap_done,
    input  logic             ap_continue,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   res,
    output logic             res_err,
    output logic [WIDTH:0]   acc
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // With LATENCY = 1 the result is computed straight from the inputs at the accept edge.
    localparam bit         DIRECT   = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cnt;
    logic [1:0]       cmd_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             accept;
    logic             load;
    logic [1:0]       op_cmd;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH:0]   op_res;
    logic [WIDTH:0]   op_acc;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            state <= IDLE;
        else if (ap_ce)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    accept     = 1'b1;
                    load       = DIRECT;
                    state_next = DIRECT ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    load       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ap_continue) begin
                    if (ap_start) begin
                        accept     = 1'b1;
                        load       = DIRECT;
                        state_next = DIRECT ? DONE : BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_cmd = DIRECT ? cmd : cmd_q;
        op_x   = DIRECT ? x : x_q;
        op_y   = DIRECT ? y : y_q;
        op_res = res;
        op_acc = acc;
        case (op_cmd)
            2'd1: op_res = {1'b0, op_x} + {1'b0, op_y};
            2'd2: op_res = {1'b0, op_x} - {1'b0, op_y};
            2'd3: begin
                op_acc = acc + {1'b0, op_x};
                op_res = op_acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            res      <= '0;
            res_err  <= 1'b0;
            acc      <= '0;
            cnt      <= 4'd0;
            cmd_q    <= 2'd0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (ap_ce) begin
            ap_ready <= accept;
            ap_done  <= (state_next == DONE);
            if (accept) begin
                cmd_q <= cmd;
                x_q   <= x;
                y_q   <= y;
                cnt   <= CNT_INIT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (load) begin
                res     <= op_res;
                acc     <= op_acc;
                res_err <= (op_cmd == 2'd0);
            end
        end
    end

    assign ap_idle = (state == IDLE);

endmodule

// File: tb/tb_hls_alu_chain.sv
// Directed bench for hls_alu_chain: a LATENCY=2 instance driven from a vector table
// plus handshake corner cases, and a LATENCY=1 instance for back-to-back streaming.
module tb_hls_alu_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       start;
    logic       cont;
    logic [1:0] cmd;
    logic [4:0] x;
    logic [4:0] y;
    logic       ready;
    logic       idle;
    logic       done;
    logic [5:0] res;
    logic       res_err;
    logic [5:0] acc;

    logic       start_1;
    logic [1:0] cmd_1;
    logic [4:0] x_1;
    logic [4:0] y_1;
    logic       ready_1;
    logic       idle_1;
    logic       done_1;
    logic [5:0] res_1;
    logic       res_err_1;
    logic [5:0] acc_1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [1:0] cmd;
        logic [4:0] x;
        logic [4:0] y;
        logic [5:0] exp_res;
        logic       exp_err;
        logic [5:0] exp_acc;
    } vec_t;

    vec_t vecs[12];
    vec_t vecs_1[5];

    always #5 clk = ~clk;

    hls_alu_chain #(.WIDTH(5), .LATENCY(2)) dut (
        .ap_clk(clk), .ap_rst(rst), .ap_ce(ce), .ap_start(start),
        .ap_ready(ready), .ap_idle(idle), .ap_done(done), .ap_continue(cont),
        .cmd(cmd), .x(x), .y(y), .res(res), .res_err(res_err), .acc(acc)
    );

    hls_alu_chain #(.WIDTH(5), .LATENCY(1)) dut_1 (
        .ap_clk(clk), .ap_rst(rst), .ap_ce(1'b1), .ap_start(start_1),
        .ap_ready(ready_1), .ap_idle(idle_1), .ap_done(done_1), .ap_continue(1'b1),
        .cmd(cmd_1), .x(x_1), .y(y_1), .res(res_1), .res_err(res_err_1), .acc(acc_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic apply_stimulus(input int idx, input vec_t v);
        int n;
        cmd   = v.cmd;
        x     = v.x;
        y     = v.y;
        start = 1'b1;
        cont  = 1'b1;
        check_output($sformatf("vec%0d_idle_before", idx), idle, 1);
        tick();
        start = 1'b0;
        check_output($sformatf("vec%0d_ready", idx), ready, 1);
        check_output($sformatf("vec%0d_done_early", idx), done, 0);
        wait_done(n);
        check_output($sformatf("vec%0d_latency", idx), n, 1);
        check_output($sformatf("vec%0d_res", idx), res, v.exp_res);
        check_output($sformatf("vec%0d_err", idx), res_err, v.exp_err);
        check_output($sformatf("vec%0d_acc", idx), acc, v.exp_acc);
        check_output($sformatf("vec%0d_ready_drop", idx), ready, 0);
        tick();
        check_output($sformatf("vec%0d_idle_after", idx), idle, 1);
        check_output($sformatf("vec%0d_done_clear", idx), done, 0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{2'd2,  5'd3,  5'd5, 6'd62, 1'b0, 6'd0};
        vecs[1]  = '{2'd1,  5'd1,  5'd2, 6'd3,  1'b0, 6'd0};
        vecs[2]  = '{2'd1, 5'd31, 5'd31, 6'd62, 1'b0, 6'd0};
        vecs[3]  = '{2'd3, 5'd20,  5'd9, 6'd20, 1'b0, 6'd20};
        vecs[4]  = '{2'd3, 5'd20,  5'd0, 6'd40, 1'b0, 6'd40};
        vecs[5]  = '{2'd3, 5'd20,  5'd0, 6'd60, 1'b0, 6'd60};
        vecs[6]  = '{2'd3, 5'd20,  5'd0, 6'd16, 1'b0, 6'd16};
        vecs[7]  = '{2'd1,  5'd4,  5'd5, 6'd9,  1'b0, 6'd16};
        vecs[8]  = '{2'd0,  5'd7,  5'd7, 6'd9,  1'b1, 6'd16};
        vecs[9]  = '{2'd2,  5'd0,  5'd1, 6'd63, 1'b0, 6'd16};
        vecs[10] = '{2'd1,  5'd0,  5'd0, 6'd0,  1'b0, 6'd16};
        vecs[11] = '{2'd2,  5'd5,  5'd3, 6'd2,  1'b0, 6'd16};

        vecs_1[0] = '{2'd1,  5'd1,  5'd1, 6'd2,  1'b0, 6'd0};
        vecs_1[1] = '{2'd1,  5'd2,  5'd3, 6'd5,  1'b0, 6'd0};
        vecs_1[2] = '{2'd2,  5'd3,  5'd5, 6'd62, 1'b0, 6'd0};
        vecs_1[3] = '{2'd3, 5'd20,  5'd0, 6'd20, 1'b0, 6'd20};
        vecs_1[4] = '{2'd1, 5'd31, 5'd31, 6'd62, 1'b0, 6'd20};

        rst = 1'b1; ce = 1'b1; start = 1'b0; cont = 1'b0;
        cmd = 2'd0; x = '0; y = '0;
        start_1 = 1'b0; cmd_1 = 2'd0; x_1 = '0; y_1 = '0;
        tick();
        tick();
        rst = 1'b0;
        check_output("rst_idle", idle, 1);
        check_output("rst_done", done, 0);
        check_output("rst_ready", ready, 0);
        check_output("rst_res", res, 0);
        check_output("rst_err", res_err, 0);
        check_output("rst_acc", acc, 0);
        check_output("rst_idle_l1", idle_1, 1);
        check_output("rst_done_l1", done_1, 0);

        for (int i = 0; i < 12; i++)
            apply_stimulus(i, vecs[i]);

        // Continue held low in DONE: a pending start must wait for it.
        cmd = 2'd1; x = 5'd10; y = 5'd3; start = 1'b1; cont = 1'b0;
        tick();
        start = 1'b0;
        wait_done(n);
        check_output("hold_done_seen", done, 1);
        check_output("hold_res_first", res, 13);
        cmd = 2'd1; x = 5'd1; y = 5'd1; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("hold%0d_done", i), done, 1);
            check_output($sformatf("hold%0d_no_ready", i), ready, 0);
            check_output($sformatf("hold%0d_res_stable", i), res, 13);
        end
        cont = 1'b1;
        tick();
        start = 1'b0;
        check_output("chain_ready", ready, 1);
        check_output("chain_done_drop", done, 0);
        tick();
        check_output("chain_done", done, 1);
        check_output("chain_res", res, 2);
        tick();
        check_output("chain_idle", idle, 1);

        // Clock enable low for three cycles while busy.
        cmd = 2'd1; x = 5'd6; y = 5'd7; start = 1'b1; cont = 1'b1;
        tick();
        start = 1'b0;
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("ce%0d_done", i), done, 0);
            check_output($sformatf("ce%0d_ready_hold", i), ready, 1);
        end
        ce = 1'b1;
        tick();
        check_output("ce_done", done, 1);
        check_output("ce_res", res, 13);
        check_output("ce_ready_drop", ready, 0);
        tick();
        check_output("ce_idle", idle, 1);

        // Reset while busy aborts the accumulate and clears the accumulator.
        cmd = 2'd3; x = 5'd5; y = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_output("abort_busy", idle, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort_idle", idle, 1);
        check_output("abort_done", done, 0);
        check_output("abort_res", res, 0);
        check_output("abort_acc", acc, 0);
        check_output("abort_ready", ready, 0);
        tick();
        check_output("abort_no_done", done, 0);

        // LATENCY=1 streaming: one result per cycle with done held high.
        start_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_1 = vecs_1[i].cmd;
            x_1   = vecs_1[i].x;
            y_1   = vecs_1[i].y;
            tick();
            check_output($sformatf("l1_vec%0d_done", i), done_1, 1);
            check_output($sformatf("l1_vec%0d_ready", i), ready_1, 1);
            check_output($sformatf("l1_vec%0d_res", i), res_1, vecs_1[i].exp_res);
            check_output($sformatf("l1_vec%0d_acc", i), acc_1, vecs_1[i].exp_acc);
        end
        start_1 = 1'b0;
        tick();
        check_output("l1_done_clear", done_1, 0);
        check_output("l1_idle", idle_1, 1);
        check_output("l1_ready_clear", ready_1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
